// File: rtl/mmio_uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register map,
// STATUS bit layout, TX state encoding and the divisor clamp helper.
package mmio_uart_pkg;

  localparam logic [13:0] SEL_BASE = 14'h2000;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // A bit period shorter than two clocks cannot be timed, so clamp it.
  function automatic logic [15:0] eff_divisor(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead synchronous FIFO: dout is the current head, push and pop may
// share an edge, and a push into a full FIFO is only taken alongside a pop.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic             push_ok_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;
  logic             do_push;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign push_ok_o = do_push;
  assign count_o   = count_q;
  assign dout_o    = mem[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 transmitter on the CPU bus at 0x8000-0x8003: bus decode,
// registers, baud/bit counters and the frame FSM around a byte FIFO.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 8,
  parameter int unsigned DEFAULT_DIVISOR = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  inout  wire  [15:0] data,
  input  logic        memNotRead,
  input  logic        memNotWrite,
  output logic        tx,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        sel;
  logic [1:0]  reg_off;
  logic        rd_en;
  logic        wr_stb;
  logic        push_req;
  logic        ovf_clr;
  logic        div_we;
  logic [15:0] rdata;

  logic        wr_q;
  logic        ovf_q, ovf_d;
  logic [15:0] div_q, div_d;
  logic        busy_q, busy_d;

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_lat_q, div_lat_d;
  logic        bit_end;
  logic        load;
  logic        pop;

  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic          push_ok;

  assign sel      = (address[15:2] == SEL_BASE);
  assign reg_off  = address[1:0];
  assign rd_en    = sel && !memNotRead && memNotWrite;
  // wr_q holds last cycle's strobe so a long low pulse is one write only.
  assign wr_stb   = sel && !memNotWrite && wr_q;
  assign push_req = wr_stb && (reg_off == REG_TXDATA);
  assign ovf_clr  = wr_stb && (reg_off == REG_STATUS) && data[STAT_OVF];
  assign div_we   = wr_stb && (reg_off == REG_DIVISOR);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_i    (push_req),
    .pop_i     (pop),
    .din_i     (data[7:0]),
    .dout_o    (fifo_dout),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count),
    .push_ok_o (push_ok)
  );

  assign count_next = fifo_count + CW'(push_ok) - CW'(pop);

  always_comb begin
    ovf_d = ovf_q;
    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    div_d = div_we ? data : div_q;
  end

  assign bit_end = (baud_q == (div_lat_q - 16'd1));

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    div_lat_d = div_lat_q;
    load      = 1'b0;
    pop       = 1'b0;

    if (state_q != TX_IDLE) begin
      baud_d = bit_end ? 16'd0 : (baud_q + 16'd1);
    end

    case (state_q)
      TX_IDLE: begin
        load = !fifo_empty;
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          bit_d   = 3'd0;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = TX_STOP;
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Divisor is sampled only here, so a mid-frame DIVISOR write waits.
    if (load) begin
      pop       = 1'b1;
      shift_d   = fifo_dout;
      div_lat_d = eff_divisor(div_q);
      baud_d    = 16'd0;
      bit_d     = 3'd0;
      state_d   = TX_START;
    end

    busy_d = (state_d != TX_IDLE) || (count_next != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q      <= 1'b1;
      ovf_q     <= 1'b0;
      div_q     <= 16'(DEFAULT_DIVISOR);
      busy_q    <= 1'b0;
      state_q   <= TX_IDLE;
      baud_q    <= 16'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      div_lat_q <= eff_divisor(16'(DEFAULT_DIVISOR));
    end else begin
      wr_q      <= memNotWrite;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      busy_q    <= busy_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      div_lat_q <= div_lat_d;
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = shift_q[0];
      default:  tx = 1'b1;
    endcase
  end

  assign busy = busy_q;

  always_comb begin
    rdata = 16'd0;
    case (reg_off)
      REG_STATUS: begin
        rdata[STAT_FULL]                   = fifo_full;
        rdata[STAT_EMPTY]                  = fifo_empty;
        rdata[STAT_BUSY]                   = busy_q;
        rdata[STAT_OVF]                    = ovf_q;
        rdata[STAT_CNT_LSB+7:STAT_CNT_LSB] = 8'(fifo_count);
      end
      REG_DIVISOR: rdata = div_q;
      default:     rdata = 16'd0;
    endcase
  end

  assign data = rd_en ? rdata : {16{1'bz}};

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped serial transmitter that answers CPU bus cycles in the upper half of the address space (address[15] = 1), the half the SRAM leaves unselected. The CPU is the bus initiator; this block is a responder on the same address/data/memNotRead/memNotWrite bus. Written bytes queue in a small FIFO and are shifted out as 8N1 frames on a single TX line at a programmable bit period.

## Interface
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥ 2
- DEFAULT_DIVISOR, 16, reset value of the DIVISOR register (clocks per bit)
- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- address  input  16  CPU address bus
- data  inout  16  CPU data bus; driven only during a selected read
- memNotRead  input  1  active-low read strobe
- memNotWrite  input  1  active-low write strobe
- tx  output  1  serial line, idle high
- busy  output  1  high while a frame is on the line or the FIFO is non-empty

## Operation
- Select: sel = (address[15:2] == 14'h2000), covering 0x8000–0x8003. No response outside this range.
- 0x8000 TXDATA (W): push data[7:0]; reads 0.
- 0x8001 STATUS (R): bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky), bits[15:8] FIFO count. Writing with data[3] = 1 clears overflow; other bits ignored.
- 0x8002 DIVISOR (R/W): 16-bit bit period in clocks. Values 0 and 1 are treated as 2.
- 0x8003: reads 0, writes ignored.
- Read: data = register value combinationally while sel && !memNotRead && memNotWrite; otherwise high-Z. Reads have no side effects.
- Write: accepted once per strobe. memNotWrite is registered (wr_q). A write is accepted on the edge where sel && !memNotWrite && wr_q == 1. It is not repeated while the strobe stays low.
- Push to a full FIFO: byte dropped and overflow set. Exception: if a pop happens on the same edge, the push is accepted.
- TX FSM: IDLE → START → DATA → STOP.
  - IDLE: tx = 1. If the FIFO is non-empty, pop the head into the shift register, latch the divisor, and go to START.
  - START: tx = 0 for one bit period.
  - DATA: 8 bit periods, LSB first, then STOP.
  - STOP: tx = 1 for one bit period. At the end of STOP, if the FIFO is non-empty, pop and go directly to START (back-to-back frames); otherwise go to IDLE.
- A DIVISOR write takes effect at the next frame start; the frame in progress is unaffected.

## Timing
- Reset (asynchronous): tx = 1, busy = 0, data high-Z, FIFO empty, count = 0, overflow = 0, DIVISOR = DEFAULT_DIVISOR, FSM = IDLE, wr_q = 1. Reset mid-frame aborts the frame and forces tx high immediately.
- Push accepted at edge N: count and empty update after edge N. If the FSM is idle, the pop and START entry happen at edge N+1, so tx falls after edge N+1.
- Each bit lasts exactly D clocks, where D is the latched divisor. A frame is 10·D clocks. Back-to-back frames have no idle gap.
- busy = (FSM != IDLE) || !empty, registered. It goes low after the edge that ends the last STOP bit.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

## Structure
- Shared package mmio_uart_pkg holds:
  - register offsets (TXDATA = 2'd0, STATUS = 2'd1, DIVISOR = 2'd2)
  - STATUS bit positions
  - FSM state encoding
  - base-select constant 14'h2000
- Sub-module uart_tx_fifo: synchronous FIFO with push, pop, din, dout, full, empty and count; push and pop may occur on the same edge. The top level holds the bus decode, registers, baud counter, bit counter and FSM.

## Test plan
- Reset then idle: tx = 1, busy = 0, STATUS reads 16'h0002, DIVISOR reads 16.
- Write DIVISOR = 4, write 0x55 to 0x8000 → tx low 4 clocks starting the edge after the push; then 1,0,1,0,1,0,1,0 at 4 clocks each; then high 4 clocks; busy low 40 clocks after the start bit begins.
- Hold memNotWrite low for 5 clocks on a TXDATA write of 0xA3 → exactly one byte queued (count = 1), one frame sent.
- DIVISOR = 2, push 9 bytes with FIFO_DEPTH = 8 while the first frame is in progress → all 9 accepted, frames back-to-back with 20-clock spacing. Push 8 more while the FIFO is full and no pop is occurring → overflow = 1. Writing STATUS with data = 16'h0008 clears it.
- Assert reset mid-DATA → tx = 1 immediately, count = 0, STATUS = 16'h0002 after release.
- Read at 0x7FFF and 0x8004 → data stays high-Z, no state change. DIVISOR write of 0 → bit period measured as 2 clocks.
